imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Parametrised, registered successor to the single-cycle immediate generator, for the pipelined core's decode stage. Accepts one 32-bit instruction and PC per valid/ready handshake. Emits the sign-extended XLEN-wide immediate, a format code and the PC, one cycle later. A 2-entry skid buffer gives full throughput while keeping in_ready registered.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; all immediates sign-extend from instruction bit 31 to XLEN.
PC_W, 32, width of the PC pass-through field.

Ports:
clk  input  1  core clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  upstream instruction valid.
in_ready  output  1  block can accept; registered.
in_instr  input  32  RISC-V instruction.
in_pc  input  PC_W  PC of in_instr, passed through unchanged.
out_valid  output  1  output entry valid.
out_ready  input  1  downstream accepts.
out_imm  output  XLEN  decoded immediate.
out_fmt  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 reserved.
out_pc  output  PC_W  PC paired with out_imm.

Behaviour:
- Decode is combinational on in_instr and is selected by opcode [6:0]:
  - I format: 0010011, 0000011, 1100111. Value is sext(instr[31:20]).
  - S format: 0100011. Value is sext({instr[31:25], instr[11:7]}).
  - B format: 1100011. Value is sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U format: 0110111, 0010111. Value is sext({instr[31:12], 12'b0}); the upper 32 bits are copies of bit 31 when XLEN=64.
  - J format: 1101111. Value is sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - Any other opcode: imm = 0, fmt = NONE. No 0xdeadbeef filler.
- Storage: output register (out_*) plus one skid register. Both hold {imm, fmt, pc, valid}.
- in_ready = !skid_valid, driven from a flop.
- Accept happens when in_valid && in_ready.
  - Accept while out_valid && !out_ready: the entry goes to the skid register; skid_valid=1; in_ready=0 from the next cycle.
  - Accept otherwise: the entry loads the output register; out_valid=1.
- Drain happens when out_valid && out_ready.
  - Skid valid: skid moves to the output register; skid_valid=0.
  - Skid empty and no accept this cycle: out_valid=0.
  - Simultaneous accept and drain with skid empty: the new entry loads the output register directly; out_valid stays 1.
- Ordering is strict FIFO. No entry is dropped or duplicated.
- Latency is 1 cycle from accept to out_valid when the output register is free. Throughput is 1 per cycle while out_ready=1.
- Full condition: skid full gives in_ready=0; in_instr is then ignored.
- Empty condition: out_valid=0; out_imm/out_fmt/out_pc hold their last values and are don't-care.
- Stability: out_imm/out_fmt/out_pc stay stable while out_valid && !out_ready.
- Reset, asserted asynchronously at any time including mid-transfer:
  - out_valid=0, skid_valid=0, in_ready=1.
  - out_imm=0, out_fmt=0, out_pc=0.
  - In-flight entries are discarded.
- XLEN values other than 32/64 are an elaboration error, raised by a generate-time check.

Optional Feature:
IMM_GEN_CSR_EN.
- Defined: opcode 1110011 with funct3 in {101, 110, 111} yields fmt=Z and imm = zero-extended instr[19:15] (zimm). Other SYSTEM encodings yield NONE/0.
- Undefined: every SYSTEM opcode yields fmt=NONE, imm=0.

Test Plan:
- XLEN=32, one beat 0xFFF00093 (addi x1,x0,-1) with out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, fmt=1, out_pc=in_pc.
- 0xFE000EE3 (beq x0,x0,-4) -> out_imm=0xFFFFFFFC, fmt=3. Also 0x002081B3 (add) -> imm=0, fmt=0.
- XLEN=64, 0x800000B7 (lui x1,0x80000) -> out_imm=0xFFFFFFFF80000000, fmt=4.
- Backpressure, out_ready=0, three back-to-back beats A, B, C:
  - A is held in the output register and B in the skid register; in_ready=0 while C is presented.
  - Raise out_ready -> A, then B, then C in order, no gaps after C's accept.
- Reset pulse asserted between clock edges while skid is full -> immediately out_valid=0 and in_ready=1; afterwards a fresh beat emerges with 1-cycle latency.
- 0x305FD073 (csrrwi x0,0x305,31):
  - With IMM_GEN_CSR_EN -> imm=0x1F, fmt=6.
  - Without the macro -> imm=0, fmt=0.

Source files
------------

// File: rtl/imm_gen_if.sv
// Handshake bundle for imm_gen_pipe: instruction/PC stream in, immediate/format/PC stream out.
// master drives the upstream side and consumes the results; slave is the generator itself.
interface imm_gen_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic [PC_W-1:0] out_pc;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_pc
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with a 2-entry skid buffer (output reg + skid reg).
// Define IMM_GEN_CSR_EN to decode CSR immediate forms (csrr*i) as fmt Z with zero-extended zimm.
module imm_gen_pipe #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32
) (
  input logic         clk,
  input logic         rst,
  imm_gen_if.slave    bus
);

  if (XLEN != 32 && XLEN != 64) begin : gen_xlen_check
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef enum logic [2:0] {
    FmtNone = 3'd0,
    FmtI    = 3'd1,
    FmtS    = 3'd2,
    FmtB    = 3'd3,
    FmtU    = 3'd4,
    FmtJ    = 3'd5,
    FmtZ    = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [PC_W-1:0] pc;
  } entry_t;

  // Combinational decode of the incoming instruction.
  logic [6:0]  opcode;
  logic [31:0] raw;
  fmt_e        fmt_dec;
  entry_t      new_entry;

  assign opcode = bus.in_instr[6:0];

  always_comb begin
    raw     = 32'b0;
    fmt_dec = FmtNone;
    case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111: begin
        raw     = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
        fmt_dec = FmtI;
      end
      7'b0100011: begin
        raw     = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
        fmt_dec = FmtS;
      end
      7'b1100011: begin
        raw     = {{20{bus.in_instr[31]}}, bus.in_instr[7], bus.in_instr[30:25],
                   bus.in_instr[11:8], 1'b0};
        fmt_dec = FmtB;
      end
      7'b0110111, 7'b0010111: begin
        raw     = {bus.in_instr[31:12], 12'b0};
        fmt_dec = FmtU;
      end
      7'b1101111: begin
        raw     = {{12{bus.in_instr[31]}}, bus.in_instr[19:12], bus.in_instr[20],
                   bus.in_instr[30:21], 1'b0};
        fmt_dec = FmtJ;
      end
`ifdef IMM_GEN_CSR_EN
      7'b1110011: begin
        if (bus.in_instr[14:12] inside {3'b101, 3'b110, 3'b111}) begin
          raw     = {27'b0, bus.in_instr[19:15]};
          fmt_dec = FmtZ;
        end
      end
`endif
      default: begin
        raw     = 32'b0;
        fmt_dec = FmtNone;
      end
    endcase
  end

  // raw is already correctly signed (or zero-extended for zimm) in 32 bits; widen from bit 31.
  always_comb begin
    new_entry          = '0;
    new_entry.imm      = {XLEN{raw[31]}};
    new_entry.imm[31:0] = raw;
    new_entry.fmt      = fmt_dec;
    new_entry.pc       = bus.in_pc;
  end

  entry_t out_q, out_d, skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   accept, drain;

  assign accept = bus.in_valid && in_ready_q;
  assign drain  = out_valid_q && bus.out_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (drain) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (!accept) begin
        out_valid_d = 1'b0;
      end
    end
    // Accept cannot coincide with a full skid since in_ready_q is low then.
    if (accept) begin
      if (out_valid_q && !bus.out_ready) begin
        skid_d       = new_entry;
        skid_valid_d = 1'b1;
      end else begin
        out_d       = new_entry;
        out_valid_d = 1'b1;
      end
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_imm   = out_q.imm;
  assign bus.out_fmt   = out_q.fmt;
  assign bus.out_pc    = out_q.pc;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode table on XLEN=32 and XLEN=64 instances, then
// backpressure ordering and asynchronous reset with a full skid buffer.
module tb_imm_gen_pipe;

  logic clk;
  logic rst;

  imm_gen_if #(.XLEN(32), .PC_W(32)) b32 ();
  imm_gen_if #(.XLEN(64), .PC_W(32)) b64 ();

  imm_gen_pipe #(.XLEN(32), .PC_W(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .PC_W(32)) dut64 (.clk(clk), .rst(rst), .bus(b64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    b32.in_valid = v;
    b32.in_instr = instr;
    b32.in_pc    = pc;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1}; // addi x1,x0,-1
    vecs[1]  = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3}; // beq -4
    vecs[2]  = '{32'h002081B3, 64'h0,                   3'd0}; // add
    vecs[3]  = '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4}; // lui 0x80000
    vecs[4]  = '{32'hFE20AC23, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2}; // sw x2,-8(x1)
    vecs[5]  = '{32'h0080006F, 64'h8,                   3'd5}; // jal x0,8
    vecs[6]  = '{32'h00812083, 64'h8,                   3'd1}; // lw x1,8(x2)
    vecs[7]  = '{32'h12345297, 64'h1234_5000,           3'd4}; // auipc x5,0x12345
    vecs[8]  = '{32'hFFC08067, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1}; // jalr x0,-4(x1)
`ifdef IMM_GEN_CSR_EN
    vecs[9]  = '{32'h305FD073, 64'h1F,                  3'd6}; // csrrwi
`else
    vecs[9]  = '{32'h305FD073, 64'h0,                   3'd0};
`endif
    vecs[10] = '{32'h00000073, 64'h0,                   3'd0}; // ecall

    rst = 1'b1;
    drive32(1'b0, 32'h0, 32'h0);
    b32.out_ready = 1'b1;
    b64.in_valid  = 1'b0;
    b64.in_instr  = 32'h0;
    b64.in_pc     = 32'h0;
    b64.out_ready = 1'b1;
    tick();
    tick();

    chk("rst_out_valid", {63'b0, b32.out_valid}, 64'd0);
    chk("rst_in_ready",  {63'b0, b32.in_ready},  64'd1);
    chk("rst_out_imm",   {32'b0, b32.out_imm},   64'd0);
    chk("rst_out_fmt",   {61'b0, b32.out_fmt},   64'd0);
    chk("rst_out_pc",    {32'b0, b32.out_pc},    64'd0);
    chk("rst_out_imm64", b64.out_imm,            64'd0);
    #3 rst = 1'b0;
    tick();

    // Back-to-back decode table, both widths, out_ready held high.
    for (int i = 0; i < NV; i++) begin
      drive32(1'b1, vecs[i].instr, 32'h1000 + 32'(i) * 4);
      b64.in_valid = 1'b1;
      b64.in_instr = vecs[i].instr;
      b64.in_pc    = 32'h1000 + 32'(i) * 4;
      tick();
      chk($sformatf("v%0d_valid32", i), {63'b0, b32.out_valid}, 64'd1);
      chk($sformatf("v%0d_imm32", i),   {32'b0, b32.out_imm},   {32'b0, vecs[i].imm[31:0]});
      chk($sformatf("v%0d_fmt32", i),   {61'b0, b32.out_fmt},   {61'b0, vecs[i].fmt});
      chk($sformatf("v%0d_pc32", i),    {32'b0, b32.out_pc},    64'h1000 + 64'(i) * 4);
      chk($sformatf("v%0d_imm64", i),   b64.out_imm,            vecs[i].imm);
      chk($sformatf("v%0d_fmt64", i),   {61'b0, b64.out_fmt},   {61'b0, vecs[i].fmt});
    end
    drive32(1'b0, 32'h0, 32'h0);
    b64.in_valid = 1'b0;
    tick();
    chk("drain_empty", {63'b0, b32.out_valid}, 64'd0);

    // Backpressure: A, B, C with out_ready low.
    b32.out_ready = 1'b0;
    drive32(1'b1, 32'hFFF00093, 32'hA0); // A: imm -1, fmt I
    tick();
    chk("bp_a_valid", {63'b0, b32.out_valid}, 64'd1);
    chk("bp_a_ready", {63'b0, b32.in_ready},  64'd1);
    drive32(1'b1, 32'h0080006F, 32'hB0); // B: imm 8, fmt J
    tick();
    chk("bp_b_inready", {63'b0, b32.in_ready}, 64'd0);
    chk("bp_a_held_pc", {32'b0, b32.out_pc},   64'hA0);
    drive32(1'b1, 32'h12345297, 32'hC0); // C: imm 0x12345000, fmt U
    tick();
    chk("bp_c_blocked", {63'b0, b32.in_ready}, 64'd0);
    chk("bp_a_stable_imm", {32'b0, b32.out_imm}, 64'hFFFF_FFFF);
    chk("bp_a_stable_pc",  {32'b0, b32.out_pc},  64'hA0);
    b32.out_ready = 1'b1;
    tick();
    chk("bp_b_pc",   {32'b0, b32.out_pc},   64'hB0);
    chk("bp_b_imm",  {32'b0, b32.out_imm},  64'h8);
    chk("bp_b_fmt",  {61'b0, b32.out_fmt},  64'd5);
    chk("bp_b_ready", {63'b0, b32.in_ready}, 64'd1);
    tick();
    chk("bp_c_valid", {63'b0, b32.out_valid}, 64'd1);
    chk("bp_c_pc",    {32'b0, b32.out_pc},    64'hC0);
    chk("bp_c_imm",   {32'b0, b32.out_imm},   64'h1234_5000);
    drive32(1'b0, 32'h0, 32'h0);
    tick();
    chk("bp_empty", {63'b0, b32.out_valid}, 64'd0);

    // Fill the skid, then reset asynchronously between edges.
    b32.out_ready = 1'b0;
    drive32(1'b1, 32'hFFF00093, 32'hD0);
    tick();
    drive32(1'b1, 32'h0080006F, 32'hE0);
    tick();
    drive32(1'b0, 32'h0, 32'h0);
    chk("pre_rst_full", {63'b0, b32.in_ready}, 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {63'b0, b32.out_valid}, 64'd0);
    chk("arst_in_ready",  {63'b0, b32.in_ready},  64'd1);
    chk("arst_out_pc",    {32'b0, b32.out_pc},    64'd0);
    #1 rst = 1'b0;
    b32.out_ready = 1'b1;
    tick();
    chk("post_rst_idle", {63'b0, b32.out_valid}, 64'd0);
    drive32(1'b1, 32'hFE000EE3, 32'hF0);
    tick();
    drive32(1'b0, 32'h0, 32'h0);
    chk("post_rst_valid", {63'b0, b32.out_valid}, 64'd1);
    chk("post_rst_imm",   {32'b0, b32.out_imm},   64'hFFFF_FFFC);
    chk("post_rst_pc",    {32'b0, b32.out_pc},    64'hF0);
    tick();
    chk("post_rst_no_stale", {63'b0, b32.out_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
